// File: rtl/accelbrot_iter_sched.sv
// Slot scheduler for the fixed-latency Mandelbrot iteration pipeline: recirculates
// unfinished tokens, injects new jobs, and retires finished tokens into a result FIFO.
module accelbrot_iter_sched #(
  parameter int LATENCY    = 8,
  parameter int ID_W       = 16,
  parameter int ITER_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ID_W-1:0]   s_id,
  output logic              pipe_clken,
  output logic              pipe_in_valid,
  output logic              pipe_in_first,
  output logic [ID_W-1:0]   pipe_in_id,
  output logic [ITER_W-1:0] pipe_in_iter,
  input  logic              pipe_out_valid,
  input  logic [ID_W-1:0]   pipe_out_id,
  input  logic [ITER_W-1:0] pipe_out_iter,
  input  logic              pipe_out_escaped,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ID_W-1:0]   m_id,
  output logic [ITER_W-1:0] m_iter,
  output logic              busy
);

  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W  = ID_W + ITER_W;

  logic [ITER_W-1:0] next_iter;
  logic [ITER_W-1:0] eff_max;
  logic              done;
  logic              recirc;
  logic              fifo_full;
  logic              accept;
  logic              push;
  logic              pop;

  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];

  // A max_iter of zero is treated as one so every token finishes after at least one pass.
  always_comb begin
    next_iter  = pipe_out_iter + ITER_W'(1);
    eff_max    = (max_iter == '0) ? ITER_W'(1) : max_iter;
    done       = pipe_out_valid && (pipe_out_escaped || (next_iter >= eff_max));
    recirc     = pipe_out_valid && !done;
    fifo_full  = (count_q == FCNT_W'(FIFO_DEPTH));
    pipe_clken = !rst && !(done && fifo_full);
    s_ready    = pipe_clken && !recirc;
    accept     = s_valid && s_ready;
    push       = done && pipe_clken;
    m_valid    = (count_q != '0);
    pop        = m_valid && m_ready;
    busy       = (inflight_q != '0) || m_valid;
  end

  always_comb begin
    pipe_in_valid = 1'b0;
    pipe_in_first = 1'b0;
    pipe_in_id    = '0;
    pipe_in_iter  = '0;
    if (!rst) begin
      if (recirc) begin
        pipe_in_valid = 1'b1;
        pipe_in_id    = pipe_out_id;
        pipe_in_iter  = next_iter;
      end else if (s_valid) begin
        pipe_in_valid = 1'b1;
        pipe_in_first = 1'b1;
        pipe_in_id    = s_id;
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !push) begin
      if (inflight_q != CNT_W'(LATENCY)) inflight_d = inflight_q + CNT_W'(1);
    end else if (push && !accept) begin
      if (inflight_q != '0) inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {pipe_out_id, next_iter};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Head is masked while empty so a drained FIFO presents zeros rather than stale data.
  always_comb begin
    {m_id, m_iter} = m_valid ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // A full pipe legitimately holds LATENCY tokens; adding one more means the bookkeeping broke.
  inflight_bound_a: assert property (@(posedge clk) disable iff (rst)
    !(accept && !push && (inflight_q == CNT_W'(LATENCY))));

endmodule

// File: tb/tb_accelbrot_iter_sched.sv
// Bench for accelbrot_iter_sched: table of combinational slot-select vectors, then
// cycle-accurate sequences against a behavioural model of the iteration pipeline.
module tb_accelbrot_iter_sched;

  localparam int L = 8;

  logic        clk;
  logic        rst;
  logic [15:0] max_iter;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_id;
  logic        pipe_clken;
  logic        pipe_in_valid;
  logic        pipe_in_first;
  logic [15:0] pipe_in_id;
  logic [15:0] pipe_in_iter;
  logic        pipe_out_valid;
  logic [15:0] pipe_out_id;
  logic [15:0] pipe_out_iter;
  logic        pipe_out_escaped;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_id;
  logic [15:0] m_iter;
  logic        busy;

  logic        use_model;
  logic [15:0] esc_pass;
  logic        tv_valid;
  logic [15:0] tv_id;
  logic [15:0] tv_iter;
  logic        tv_esc;

  logic        st_valid [L];
  logic [15:0] st_id    [L];
  logic [15:0] st_iter  [L];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] max_iter;
    logic        s_valid;
    logic [15:0] s_id;
    logic        po_valid;
    logic [15:0] po_id;
    logic [15:0] po_iter;
    logic        po_esc;
    logic        e_valid;
    logic        e_first;
    logic [15:0] e_id;
    logic [15:0] e_iter;
    logic        e_s_ready;
  } vec_t;

  typedef struct {
    logic [15:0] id;
    logic [15:0] iter;
    int          cyc;
  } exp_t;

  vec_t vecs [12];
  exp_t exp_q [$];

  accelbrot_iter_sched dut (
    .clk              (clk),
    .rst              (rst),
    .max_iter         (max_iter),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_id             (s_id),
    .pipe_clken       (pipe_clken),
    .pipe_in_valid    (pipe_in_valid),
    .pipe_in_first    (pipe_in_first),
    .pipe_in_id       (pipe_in_id),
    .pipe_in_iter     (pipe_in_iter),
    .pipe_out_valid   (pipe_out_valid),
    .pipe_out_id      (pipe_out_id),
    .pipe_out_iter    (pipe_out_iter),
    .pipe_out_escaped (pipe_out_escaped),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_id             (m_id),
    .m_iter           (m_iter),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural iteration pipeline: L stages advancing only when the scheduler enables it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        st_valid[i] <= 1'b0;
        st_id[i]    <= 16'd0;
        st_iter[i]  <= 16'd0;
      end
    end else if (pipe_clken) begin
      st_valid[0] <= pipe_in_valid;
      st_id[0]    <= pipe_in_id;
      st_iter[0]  <= pipe_in_iter;
      for (int i = 1; i < L; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_id[i]    <= st_id[i-1];
        st_iter[i]  <= st_iter[i-1];
      end
    end
  end

  // A token escapes on the pass whose completed count would equal esc_pass.
  always_comb begin
    if (use_model) begin
      pipe_out_valid   = st_valid[L-1];
      pipe_out_id      = st_id[L-1];
      pipe_out_iter    = st_iter[L-1];
      pipe_out_escaped = st_valid[L-1] && ((st_iter[L-1] + 16'd1) == esc_pass);
    end else begin
      pipe_out_valid   = tv_valid;
      pipe_out_id      = tv_id;
      pipe_out_iter    = tv_iter;
      pipe_out_escaped = tv_esc;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checkOutput(name, {63'd0, act}, {63'd0, exp});
  endtask

  task automatic chkSlot(input string name, input logic sr, input logic v, input logic f,
                         input logic [15:0] id, input logic [15:0] it);
    checkOutput(name, {29'd0, s_ready, pipe_in_valid, pipe_in_first, pipe_in_id, pipe_in_iter},
                {29'd0, sr, v, f, id, it});
  endtask

  task automatic applyStimulus(input logic sv, input logic [15:0] sid, input logic mr);
    s_valid = sv;
    s_id    = sid;
    m_ready = mr;
  endtask

  task automatic addExpected(input logic [15:0] id, input logic [15:0] it, input int cyc);
    exp_t e;
    e.id   = id;
    e.iter = it;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Every popped result must be the next expected one, on the expected cycle.
  task automatic checkResults(input int c);
    exp_t e;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_result: got id %h iter %h at cycle %0d, expected none",
                 m_id, m_iter, c);
      end else begin
        e = exp_q.pop_front();
        checkOutput("result", {c, m_id, m_iter}, {e.cyc, e.id, e.iter});
      end
    end
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, {32'd0, exp_q.size()}, 64'd0);
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [15:0] mi);
    rst       = 1'b1;
    use_model = 1'b1;
    esc_pass  = 16'd0;
    max_iter  = mi;
    applyStimulus(1'b0, 16'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    vecs[0]  = '{16'd1,     1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[1]  = '{16'd1,     1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b1};
    vecs[2]  = '{16'd3,     1'b1, 16'h0077, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0001, 1'b0};
    vecs[3]  = '{16'd3,     1'b1, 16'h0022, 1'b1, 16'h0006, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0022, 16'h0000, 1'b1};
    vecs[4]  = '{16'd100,   1'b0, 16'h0000, 1'b1, 16'h0009, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[5]  = '{16'd0,     1'b1, 16'h0003, 1'b1, 16'h0008, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000, 1'b1};
    vecs[6]  = '{16'hFFFF,  1'b1, 16'h0055, 1'b1, 16'hABCD, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'h0000, 1'b0};
    vecs[7]  = '{16'hFFFF,  1'b0, 16'h0000, 1'b1, 16'h0002, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{16'd5,     1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0004, 1'b0};
    vecs[9]  = '{16'd5,     1'b0, 16'h0000, 1'b0, 16'h0004, 16'h0009, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{16'd5,     1'b1, 16'h0099, 1'b1, 16'h0001, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0099, 16'h0000, 1'b1};
    vecs[11] = '{16'd2,     1'b0, 16'h0000, 1'b1, 16'hF00D, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hF00D, 16'h0001, 1'b0};

    tv_valid = 1'b0;
    tv_id    = 16'd0;
    tv_iter  = 16'd0;
    tv_esc   = 1'b0;

    // Reset state, with a job offered to show nothing leaks into the slot.
    rst       = 1'b1;
    use_model = 1'b1;
    esc_pass  = 16'd0;
    max_iter  = 16'd1;
    applyStimulus(1'b1, 16'hBEEF, 1'b1);
    @(negedge clk);
    checkOutput("reset_state",
                {27'd0, m_valid, busy, s_ready, pipe_clken, pipe_in_valid, m_id, m_iter}, 64'd0);

    // Slot-select table with pipe_out driven directly.
    doReset(16'd1);
    use_model = 1'b0;
    for (int i = 0; i < 12; i++) begin
      max_iter = vecs[i].max_iter;
      applyStimulus(vecs[i].s_valid, vecs[i].s_id, 1'b1);
      tv_valid = vecs[i].po_valid;
      tv_id    = vecs[i].po_id;
      tv_iter  = vecs[i].po_iter;
      tv_esc   = vecs[i].po_esc;
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i),
                  {28'd0, pipe_clken, s_ready, pipe_in_valid, pipe_in_first, pipe_in_id, pipe_in_iter},
                  {28'd0, 1'b1, vecs[i].e_s_ready, vecs[i].e_valid, vecs[i].e_first,
                   vecs[i].e_id, vecs[i].e_iter});
      tick();
    end
    tv_valid = 1'b0;

    // Eight single-pass jobs back to back.
    doReset(16'd1);
    for (int k = 0; k < 8; k++) addExpected(16'(k), 16'd1, 9 + k);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(c < 8, 16'(c), 1'b1);
      @(negedge clk);
      checkResults(c);
      if (c < 8) chk1($sformatf("a_s_ready_c%0d", c), s_ready, 1'b1);
      if (c == 16) chk1("a_busy_last", busy, 1'b1);
      if (c == 17) chk1("a_busy_idle", busy, 1'b0);
      tick();
    end
    checkDrained("a_drained");

    // Three passes, no escape.
    doReset(16'd3);
    addExpected(16'd5, 16'd3, 25);
    for (int c = 0; c < 28; c++) begin
      applyStimulus(c == 0, 16'd5, 1'b1);
      @(negedge clk);
      checkResults(c);
      if (c == 8)  chkSlot("b_recirc1", 1'b0, 1'b1, 1'b0, 16'd5, 16'd1);
      if (c == 16) chkSlot("b_recirc2", 1'b0, 1'b1, 1'b0, 16'd5, 16'd2);
      if (c == 24) chk1("b_m_valid_before", m_valid, 1'b0);
      tick();
    end
    checkDrained("b_drained");

    // Escape on pass 2; blocked offers wait for a free slot.
    doReset(16'd100);
    esc_pass = 16'd2;
    addExpected(16'd9,  16'd2, 17);
    addExpected(16'd11, 16'd2, 26);
    addExpected(16'd10, 16'd2, 33);
    for (int c = 0; c < 36; c++) begin
      applyStimulus((c == 0) || (c == 8) || (c == 9) || (c == 16),
                    (c == 0) ? 16'd9 : ((c < 16) ? 16'd11 : 16'd10), 1'b1);
      @(negedge clk);
      checkResults(c);
      if (c == 8)  chkSlot("c_blocked", 1'b0, 1'b1, 1'b0, 16'd9, 16'd1);
      if (c == 9)  chkSlot("c_late_inject", 1'b1, 1'b1, 1'b1, 16'd11, 16'd0);
      if (c == 16) chkSlot("c_inject_on_retire", 1'b1, 1'b1, 1'b1, 16'd10, 16'd0);
      tick();
    end
    checkDrained("c_drained");

    // FIFO fills, the fifth retirement stalls until one pop.
    doReset(16'd1);
    addExpected(16'd20, 16'd1, 15);
    addExpected(16'd21, 16'd1, 18);
    addExpected(16'd22, 16'd1, 19);
    addExpected(16'd23, 16'd1, 20);
    addExpected(16'd24, 16'd1, 21);
    for (int c = 0; c < 24; c++) begin
      applyStimulus(c < 5, 16'(20 + c), (c == 15) || (c >= 18));
      @(negedge clk);
      checkResults(c);
      if (c == 11) chk1("d_clken_pre", pipe_clken, 1'b1);
      if ((c >= 12) && (c <= 15)) chk1($sformatf("d_stall_c%0d", c), pipe_clken, 1'b0);
      if (c == 13) chk1("d_s_ready_stall", s_ready, 1'b0);
      if (c == 16) chk1("d_release", pipe_clken, 1'b1);
      if (c == 22) chk1("d_busy_idle", busy, 1'b0);
      tick();
    end
    checkDrained("d_drained");

    // Mid-operation reset discards in-flight and buffered tokens.
    doReset(16'd1);
    for (int c = 0; c < 9; c++) begin
      applyStimulus((c == 0) || ((c >= 2) && (c <= 4)), 16'(30 + c), 1'b0);
      @(negedge clk);
      checkResults(c);
      if (c == 8) chk1("e_busy_pre", busy, 1'b1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("e_reset_now", {61'd0, m_valid, busy, pipe_clken}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    addExpected(16'd7, 16'd1, 9);
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c == 0, 16'd7, 1'b1);
      @(negedge clk);
      checkResults(c);
      tick();
    end
    checkDrained("e_drained");

    // max_iter of zero finishes after one pass.
    doReset(16'd0);
    addExpected(16'd40, 16'd1, 9);
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c == 0, 16'd40, 1'b1);
      @(negedge clk);
      checkResults(c);
      if (c == 8) chkSlot("f_no_recirc", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
    end
    checkDrained("f_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
